// File: rtl/icache_axi_rd_bridge_if.sv
// icache_axi_rd_bridge_if
// Bundles the icache refill request/return handshake and the AXI4 read
// address / read data channels used by icache_axi_rd_bridge.
//   master modport : the bridge (issues AXI reads, answers the icache)
//   slave  modport : the environment (icache requester + AXI read slave)
// Signals:
//   rd_req, rd_uncache, rd_addr, rd_rdy      icache request side
//   ret_valid, ret_data                      icache return side
//   arid, araddr, arlen, arsize, arburst,
//   arvalid, arready                         AXI read address channel
//   rid, rdata, rresp, rlast, rvalid, rready AXI read data channel
// Build option ICACHE_AXI_RRESP_CHK_EN adds ret_err (bridge output).
interface icache_axi_rd_bridge_if;

    logic         rd_req;
    logic         rd_uncache;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [127:0] ret_data;
`ifdef ICACHE_AXI_RRESP_CHK_EN
    logic         ret_err;
`endif

    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;

    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    modport master (
        input  rd_req, rd_uncache, rd_addr,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rd_rdy, ret_valid, ret_data,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready
`ifdef ICACHE_AXI_RRESP_CHK_EN
        , output ret_err
`endif
    );

    modport slave (
        output rd_req, rd_uncache, rd_addr,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rd_rdy, ret_valid, ret_data,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready
`ifdef ICACHE_AXI_RRESP_CHK_EN
        , input ret_err
`endif
    );

endinterface

// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge
// Read-only AXI4 master servicing the icache miss / uncached read port.
// A cached request becomes a LINE_BEATS-beat INCR burst, an uncached request
// a single-beat read. Returned beats are assembled into one 128-bit word and
// handed back with a one-cycle ret_valid pulse.
// Ports:
//   clk_g   core clock
//   resetn  synchronous, active-low reset
//   bus     icache_axi_rd_bridge_if.master (icache request/return, AXI AR/R)
// Parameters:
//   AXI_ID      constant ARID
//   LINE_BEATS  words per cache line (arlen = LINE_BEATS-1 for cached reads)
// Build option:
//   ICACHE_AXI_RRESP_CHK_EN  adds bus.ret_err, a per-transaction sticky flag
//                            set by any accepted beat with rresp != OKAY.
module icache_axi_rd_bridge #(
    parameter logic [3:0]  AXI_ID     = 4'h0,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic                   clk_g,
    input  logic                   resetn,
    icache_axi_rd_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } state_t;

    localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);
    localparam logic [2:0] AR_SIZE  = 3'b010;  // 4-byte beats
    localparam logic [1:0] AR_INCR  = 2'b01;

    state_t       state;
    state_t       state_nxt;

    logic         uncache_q;
    logic [31:0]  addr_q;
    logic [1:0]   cnt_q;
    logic [127:0] data_q;

    logic         req_any;
    logic         beat_ok;
    logic         last_beat;
    logic [7:0]   len_cur;

    logic         rd_rdy_c;
    logic         arvalid_c;
    logic         rready_c;
    logic         ret_valid_c;

    assign req_any   = bus.rd_req | bus.rd_uncache;
    assign len_cur   = uncache_q ? 8'd0 : LINE_LEN;
    assign beat_ok   = rready_c & bus.rvalid;
    // Terminate on rlast or once the requested length is reached, whichever
    // comes first.
    assign last_beat = bus.rlast | ({6'b0, cnt_q} == len_cur);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = AR;
            AR:      if (bus.arready) state_nxt = R;
            R:       if (bus.rvalid && last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Handshake outputs are qualified by resetn so that an asserted reset
    // never advertises acceptance or a live AXI request.
    always_comb begin
        rd_rdy_c    = 1'b0;
        arvalid_c   = 1'b0;
        rready_c    = 1'b0;
        ret_valid_c = 1'b0;
        if (resetn) begin
            case (state)
                IDLE:    rd_rdy_c    = req_any;
                AR:      arvalid_c   = 1'b1;
                R:       rready_c    = 1'b1;
                DONE:    ret_valid_c = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            uncache_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
        end else if (rd_rdy_c) begin
            // uncache wins when both request lines are high
            uncache_q <= bus.rd_uncache;
            addr_q    <= bus.rd_addr;
            cnt_q     <= '0;
            data_q    <= '0;
        end else if (beat_ok) begin
            if (uncache_q) begin
                data_q[127:96] <= bus.rdata;
            end else begin
                data_q[{cnt_q, 5'b00000} +: 32] <= bus.rdata;
            end
            cnt_q <= cnt_q + 2'd1;
        end
    end

`ifdef ICACHE_AXI_RRESP_CHK_EN
    logic err_q;

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (rd_rdy_c) begin
            err_q <= 1'b0;
        end else if (beat_ok && (bus.rresp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.ret_err = ret_valid_c & err_q;

    // rid is not checked: only one transaction is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^bus.rid;
`else
    // rid and rresp carry no information for this block in this build.
    logic unused_rsp;
    assign unused_rsp = ^{bus.rid, bus.rresp};
`endif

    // AR fields read as zero outside the address phase and are held from the
    // latched request while arvalid is high.
    assign bus.rd_rdy    = rd_rdy_c;
    assign bus.arvalid   = arvalid_c;
    assign bus.araddr    = arvalid_c ? addr_q  : '0;
    assign bus.arid      = arvalid_c ? AXI_ID  : '0;
    assign bus.arlen     = arvalid_c ? len_cur : '0;
    assign bus.arsize    = arvalid_c ? AR_SIZE : '0;
    assign bus.arburst   = arvalid_c ? AR_INCR : '0;
    assign bus.rready    = rready_c;
    assign bus.ret_valid = ret_valid_c;
    assign bus.ret_data  = data_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// tb_icache_axi_rd_bridge
// Directed bench for icache_axi_rd_bridge. A request-level model tracks what
// the bridge must show each cycle; literal expectations pin key results.
module tb_icache_axi_rd_bridge;

    logic clk_g = 1'b0;
    logic resetn;
    always #5 clk_g = ~clk_g;

    icache_axi_rd_bridge_if bif ();

    icache_axi_rd_bridge #(
        .AXI_ID     (4'h0),
        .LINE_BEATS (4)
    ) dut (
        .clk_g  (clk_g),
        .resetn (resetn),
        .bus    (bif.master)
    );

    int total = 0;
    int bad   = 0;

    int cyc        = 0;
    int pulses     = 0;
    int arv_cycles = 0;
    int acc_cyc    = 0;
    int ret_cyc    = 0;
    logic [127:0] last_ret    = '0;
    logic [31:0]  last_araddr = '0;
    logic [7:0]   last_arlen  = '0;
    logic         last_err    = 1'b0;

    logic [31:0] beats [4];
    logic [1:0]  resp  [4];

    // request-level model
    bit           m_pend = 0;
    int           m_left = 0;
    bit           m_done = 0;
    bit           m_unc  = 0;
    bit           m_err  = 0;
    int           m_got  = 0;
    logic [31:0]  m_addr = '0;
    logic [127:0] m_line = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_g);
        #1;
    endtask

    task automatic set_beats(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3);
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    endtask

    // Present a request for one cycle (accepted immediately when idle), then
    // scramble rd_addr to show the bridge latched it.
    task automatic run_req(input bit req, input bit unc, input logic [31:0] addr);
        bif.rd_req     = req;
        bif.rd_uncache = unc;
        bif.rd_addr    = addr;
        step();
        bif.rd_req     = 1'b0;
        bif.rd_uncache = 1'b0;
        bif.rd_addr    = 32'hFFFF_FFF0;
    endtask

    // AXI read slave: stall AR for ar_stall cycles of arvalid, then return nb
    // beats with gap idle cycles between them.
    task automatic serve(input int nb, input int ar_stall, input int gap, input bit rlast_on);
        int seen = 0;
        int beat = 0;
        int gapc = 0;
        int n    = 0;
        bit ar_done = 0;
        bit acc;
        bif.arready = (ar_stall == 0);
        while (beat < nb && n < 200) begin
            @(negedge clk_g);
            n++;
            acc = 0;
            if (!ar_done) begin
                if (bif.arvalid && bif.arready) ar_done = 1;
                else if (bif.arvalid) seen++;
            end else if (bif.rvalid && bif.rready) begin
                beat++;
                acc = 1;
            end
            @(posedge clk_g);
            #1;
            if (!ar_done) begin
                bif.arready = (seen >= ar_stall);
            end else begin
                bif.arready = 1'b0;
                if (acc) gapc = gap;
                if (beat >= nb) begin
                    bif.rvalid = 1'b0;
                    bif.rlast  = 1'b0;
                end else if (gapc > 0) begin
                    bif.rvalid = 1'b0;
                    bif.rlast  = 1'b0;
                    gapc--;
                end else begin
                    bif.rvalid = 1'b1;
                    bif.rdata  = beats[beat];
                    bif.rresp  = resp[beat];
                    bif.rlast  = rlast_on && (beat == nb - 1);
                end
            end
        end
        chk("serve_beats", 128'(beat), 128'(nb));
    endtask

    // Compare DUT against the model every cycle out of reset, then advance
    // the model with the inputs that the next edge will see.
    initial begin : monitor
        bit exp_rdy;
        forever begin
            @(negedge clk_g);
            cyc++;
            if (resetn) begin
                exp_rdy = !(m_pend || m_left > 0 || m_done) && (bif.rd_req || bif.rd_uncache);
                chk("rd_rdy",    128'(bif.rd_rdy),    128'(exp_rdy));
                chk("arvalid",   128'(bif.arvalid),   128'(m_pend));
                chk("rready",    128'(bif.rready),    128'(m_left > 0));
                chk("ret_valid", 128'(bif.ret_valid), 128'(m_done));
                chk("ret_data",  bif.ret_data,        m_line);
`ifdef ICACHE_AXI_RRESP_CHK_EN
                chk("ret_err",   128'(bif.ret_err),   128'(m_done && m_err));
`endif
                if (m_pend) begin
                    chk("araddr",  128'(bif.araddr),  128'(m_addr));
                    chk("arlen",   128'(bif.arlen),   m_unc ? 128'd0 : 128'd3);
                    chk("arsize",  128'(bif.arsize),  128'd2);
                    chk("arburst", 128'(bif.arburst), 128'd1);
                    chk("arid",    128'(bif.arid),    128'd0);
                end
                if (bif.rd_rdy) acc_cyc = cyc;
                if (bif.arvalid) begin
                    arv_cycles++;
                    last_araddr = bif.araddr;
                    last_arlen  = bif.arlen;
                end
                if (bif.ret_valid) begin
                    pulses++;
                    ret_cyc  = cyc;
                    last_ret = bif.ret_data;
`ifdef ICACHE_AXI_RRESP_CHK_EN
                    last_err = bif.ret_err;
`endif
                end
            end

            if (!resetn) begin
                m_pend = 0; m_left = 0; m_done = 0; m_err = 0; m_got = 0;
                m_line = '0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_left > 0) begin
                if (bif.rvalid) begin
                    if (m_unc) m_line[127:96] = bif.rdata;
                    else       m_line[m_got*32 +: 32] = bif.rdata;
                    if (bif.rresp != 2'b00) m_err = 1;
                    m_got++;
                    m_left--;
                    if (bif.rlast) m_left = 0;
                    if (m_left == 0) m_done = 1;
                end
            end else if (m_pend) begin
                if (bif.arready) begin
                    m_pend = 0;
                    m_left = m_unc ? 1 : 4;
                end
            end else if (bif.rd_req || bif.rd_uncache) begin
                m_pend = 1;
                m_unc  = bif.rd_uncache;
                m_addr = bif.rd_addr;
                m_line = '0;
                m_err  = 0;
                m_got  = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int p0;
        resetn         = 1'b0;
        bif.rd_req     = 1'b0;
        bif.rd_uncache = 1'b0;
        bif.rd_addr    = '0;
        bif.arready    = 1'b0;
        bif.rid        = '0;
        bif.rdata      = '0;
        bif.rresp      = '0;
        bif.rlast      = 1'b0;
        bif.rvalid     = 1'b0;
        for (int i = 0; i < 4; i++) resp[i] = 2'b00;
        set_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

        repeat (3) @(posedge clk_g);
        #1;
        chk("rst_arvalid",   128'(bif.arvalid),   128'd0);
        chk("rst_rready",    128'(bif.rready),    128'd0);
        chk("rst_ret_valid", 128'(bif.ret_valid), 128'd0);
        chk("rst_rd_rdy",    128'(bif.rd_rdy),    128'd0);
        chk("rst_ret_data",  bif.ret_data,        128'd0);
        resetn = 1'b1;
        step();

        // cached, zero-wait
        p0 = pulses;
        run_req(1'b1, 1'b0, 32'h1FC0_0010);
        serve(4, 0, 0, 1'b1);
        repeat (3) step();
        chk("c_data",    last_ret, 128'h44444444_33333333_22222222_11111111);
        chk("c_araddr",  128'(last_araddr), 128'h1FC00010);
        chk("c_arlen",   128'(last_arlen), 128'd3);
        chk("c_pulses",  128'(pulses - p0), 128'd1);
        chk("c_latency", 128'(ret_cyc - acc_cyc), 128'd6);

        // uncached, zero-wait
        p0 = pulses;
        beats[0] = 32'hDEADBEEF;
        run_req(1'b0, 1'b1, 32'hBFC0_0000);
        serve(1, 0, 0, 1'b1);
        repeat (3) step();
        chk("u_data",    last_ret, 128'hDEADBEEF_00000000_00000000_00000000);
        chk("u_arlen",   128'(last_arlen), 128'd0);
        chk("u_pulses",  128'(pulses - p0), 128'd1);
        chk("u_latency", 128'(ret_cyc - acc_cyc), 128'd3);

        // backpressure, with a stray rvalid before the address handshake
        set_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        bif.rvalid = 1'b1;
        bif.rdata  = 32'hCAFEF00D;
        arv_cycles = 0;
        p0 = pulses;
        run_req(1'b1, 1'b0, 32'h1FC0_0010);
        serve(4, 5, 2, 1'b1);
        repeat (3) step();
        chk("bp_data",   last_ret, 128'h44444444_33333333_22222222_11111111);
        chk("bp_arvcyc", 128'(arv_cycles), 128'd6);
        chk("bp_pulses", 128'(pulses - p0), 128'd1);

        // back-to-back with rd_req held
        p0 = pulses;
        set_beats(32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3);
        bif.rd_req  = 1'b1;
        bif.rd_addr = 32'h1FC0_0040;
        step();
        serve(4, 0, 0, 1'b1);
        chk("b2b_done_valid", 128'(bif.ret_valid), 128'd1);
        chk("b2b_done_rdy",   128'(bif.rd_rdy),    128'd0);
        step();
        chk("b2b_idle_rdy",   128'(bif.rd_rdy),    128'd1);
        chk("b2b_hold_data",  bif.ret_data, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        set_beats(32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3);
        step();
        bif.rd_req = 1'b0;
        serve(4, 0, 0, 1'b1);
        repeat (3) step();
        chk("b2b_data2",  last_ret, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
        chk("b2b_pulses", 128'(pulses - p0), 128'd2);

        // cached with no rlast: the bridge ends on the fourth beat itself
        p0 = pulses;
        set_beats(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
        run_req(1'b1, 1'b0, 32'h1FC0_0080);
        serve(4, 0, 0, 1'b0);
        repeat (3) step();
        chk("nolast_data",   last_ret, 128'h0D0E0F10_090A0B0C_05060708_01020304);
        chk("nolast_pulses", 128'(pulses - p0), 128'd1);

        // cached with an early rlast on beat 2
        p0 = pulses;
        run_req(1'b1, 1'b0, 32'h1FC0_0090);
        serve(2, 0, 0, 1'b1);
        repeat (3) step();
        chk("early_data",   last_ret, 128'h00000000_00000000_05060708_01020304);
        chk("early_pulses", 128'(pulses - p0), 128'd1);

        // rd_req and rd_uncache together: uncached wins
        beats[0] = 32'h5A5A1234;
        run_req(1'b1, 1'b1, 32'h1FC0_00C0);
        serve(1, 0, 0, 1'b1);
        repeat (3) step();
        chk("both_arlen",  128'(last_arlen), 128'd0);
        chk("both_araddr", 128'(last_araddr), 128'h1FC000C0);
        chk("both_data",   last_ret, 128'h5A5A1234_00000000_00000000_00000000);

        // reset after beat 2
        p0 = pulses;
        set_beats(32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3);
        run_req(1'b1, 1'b0, 32'h1FC0_0100);
        serve(2, 0, 0, 1'b0);
        resetn = 1'b0;
        step();
        chk("mrst_arvalid",   128'(bif.arvalid),   128'd0);
        chk("mrst_rready",    128'(bif.rready),    128'd0);
        chk("mrst_ret_valid", 128'(bif.ret_valid), 128'd0);
        chk("mrst_ret_data",  bif.ret_data,        128'd0);
        resetn = 1'b1;
        repeat (2) step();
        chk("mrst_pulses", 128'(pulses - p0), 128'd0);
        p0 = pulses;
        set_beats(32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3);
        run_req(1'b1, 1'b0, 32'h1FC0_0200);
        serve(4, 0, 0, 1'b1);
        repeat (3) step();
        chk("mrst_after_data",   last_ret, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
        chk("mrst_after_pulses", 128'(pulses - p0), 128'd1);

`ifdef ICACHE_AXI_RRESP_CHK_EN
        // SLVERR on beat 3, then a clean line
        resp[2] = 2'b10;
        run_req(1'b1, 1'b0, 32'h1FC0_0300);
        serve(4, 0, 0, 1'b1);
        repeat (3) step();
        chk("err_flag", 128'(last_err), 128'd1);
        chk("err_data", last_ret, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
        resp[2] = 2'b00;
        run_req(1'b1, 1'b0, 32'h1FC0_0340);
        serve(4, 0, 0, 1'b1);
        repeat (3) step();
        chk("err_clean", 128'(last_err), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
